// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack CPU data-memory responder.
// Holds the address-map region type, fixed I/O addresses, payload widths
// and the address decoder used by the top level.
package hack_mem_pkg;

  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_SCREEN,
    REGION_KBD,
    REGION_SW,
    REGION_UNMAPPED
  } t_mem_region;

  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR    = 15'h6000;
  localparam logic [14:0] SW_ADDR     = 15'h6001;

  localparam int unsigned SCR_OFF_W   = 13;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned SCR_ENTRY_W = SCR_OFF_W + WORD_W;

  // Map a CPU data address onto its region.
  function automatic t_mem_region decode_region(input logic [14:0] addr);
    t_mem_region r;
    r = REGION_UNMAPPED;
    if (!addr[14])                                r = REGION_RAM;
    else if ((addr & 15'h6000) == SCREEN_BASE)    r = REGION_SCREEN;
    else if (addr == KBD_ADDR)                    r = REGION_KBD;
    else if (addr == SW_ADDR)                     r = REGION_SW;
    return r;
  endfunction

endpackage

// File: rtl/scr_wr_fifo.sv
// Synchronous FIFO posting screen writes toward the framebuffer.
// Ports: clk, rst (async, active-high), push/din, pop, full, empty, head.
// Pushes while full and pops while empty are ignored. Pointers carry one
// extra wrap bit so full/empty are distinguished without a counter.
module scr_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the queue immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cpu_data_responder.sv
// Responder for the Hack CPU data-memory port.
// Ports:
//   Clock, Reset        - clock and async active-high reset
//   data_addr, write_m, out_m - CPU request; in_m - registered read data
//   cpu_stall           - SCREEN write refused because the post FIFO is full
//   SW, kbd_code        - board switches (async) and keyboard scan code
//   scr_valid/ready/addr/data - posted framebuffer write handshake
//   bad_wr_cnt          - saturating count of writes to read-only/unmapped space
module cpu_data_responder
  import hack_mem_pkg::*;
#(
  parameter int unsigned RAM_AW     = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [14:0]          data_addr,
  input  logic                 write_m,
  input  logic [WORD_W-1:0]    out_m,
  output logic [WORD_W-1:0]    in_m,
  output logic                 cpu_stall,
  input  logic [3:0]           SW,
  input  logic [WORD_W-1:0]    kbd_code,
  output logic                 scr_valid,
  input  logic                 scr_ready,
  output logic [SCR_OFF_W-1:0] scr_addr,
  output logic [WORD_W-1:0]    scr_data,
  output logic [7:0]           bad_wr_cnt
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  t_mem_region            region;
  logic [RAM_AW-1:0]      ram_idx;
  logic [WORD_W-1:0]      ram [RAM_WORDS];
  logic                   ram_we;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic [SCR_ENTRY_W-1:0] fifo_head;
  logic                   bad_wr;
  logic [3:0]             sw_meta;
  logic [3:0]             sw_sync;

  assign region  = decode_region(data_addr);
  assign ram_idx = data_addr[RAM_AW-1:0];

  // Stall only SCREEN writes; fullness is taken before any same-cycle pop.
  assign cpu_stall = write_m && (region == REGION_SCREEN) && fifo_full;
  assign fifo_push = write_m && (region == REGION_SCREEN) && !fifo_full;
  assign ram_we    = write_m && (region == REGION_RAM);
  assign bad_wr    = write_m && (region inside {REGION_KBD, REGION_SW, REGION_UNMAPPED});

  assign scr_valid = !fifo_empty;
  assign scr_addr  = fifo_head[SCR_ENTRY_W-1:WORD_W];
  assign scr_data  = fifo_head[WORD_W-1:0];

  scr_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SCR_ENTRY_W)
  ) u_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (fifo_push),
    .din   ({data_addr[SCR_OFF_W-1:0], out_m}),
    .pop   (scr_valid && scr_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // RAM array; contents survive reset.
  always_ff @(posedge Clock) begin
    if (ram_we) ram[ram_idx] <= out_m;
  end

  // Two-flop synchronizer for the asynchronous switches.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  // Registered read mux; a RAM write forwards its own data (write-first).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      in_m <= '0;
    end else begin
      case (region)
        REGION_RAM:  in_m <= ram_we ? out_m : ram[ram_idx];
        REGION_KBD:  in_m <= kbd_code;
        REGION_SW:   in_m <= {12'b0, sw_sync};
        default:     in_m <= '0;
      endcase
    end
  end

  // Saturating dropped-write counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bad_wr_cnt <= '0;
    end else if (bad_wr && (bad_wr_cnt != 8'hFF)) begin
      bad_wr_cnt <= bad_wr_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cpu_data_responder.sv
// Self-checking bench for cpu_data_responder: a queue/array model of the
// address map checked every cycle, plus literal expectations at key points.
module tb_cpu_data_responder;

  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [14:0] data_addr = '0;
  logic        write_m = 1'b0;
  logic [15:0] out_m = '0;
  logic [15:0] in_m;
  logic        cpu_stall;
  logic [3:0]  SW = '0;
  logic [15:0] kbd_code = '0;
  logic        scr_valid;
  logic        scr_ready = 1'b0;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic [7:0]  bad_wr_cnt;

  always #5 Clock = ~Clock;

  cpu_data_responder #(.RAM_AW(10), .FIFO_DEPTH(DEPTH)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .data_addr  (data_addr),
    .write_m    (write_m),
    .out_m      (out_m),
    .in_m       (in_m),
    .cpu_stall  (cpu_stall),
    .SW         (SW),
    .kbd_code   (kbd_code),
    .scr_valid  (scr_valid),
    .scr_ready  (scr_ready),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .bad_wr_cnt (bad_wr_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] m_ram [1024];
  bit          m_known [1024];
  logic [28:0] m_q [$];
  int          m_bad;
  logic [3:0]  m_sw1, m_sw2;
  logic [15:0] m_in;
  bit          m_in_known;
  logic [12:0] popped [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 RAM, 1 SCREEN, 2 KBD, 3 SW, 4 unmapped
  function automatic int region_of(input logic [14:0] a);
    int v;
    v = int'(a);
    if (v < 16384) return 0;
    if (v < 24576) return 1;
    if (v == 24576) return 2;
    if (v == 24577) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_bad = 0;
    m_sw1 = '0;
    m_sw2 = '0;
    m_in = '0;
    m_in_known = 1'b1;
  endtask

  // One clock: check the combinational stall, advance the model, check outputs.
  task automatic cycle();
    int r, idx;
    bit stall, pop, wr;
    logic [14:0] a;
    logic [15:0] d;
    logic [12:0] off;
    a = data_addr; d = out_m; wr = write_m;
    r = region_of(a);
    idx = int'(a) % 1024;
    off = a[12:0];
    stall = wr && r == 1 && m_q.size() == DEPTH;
    pop = m_q.size() > 0 && scr_ready;
    chk("cpu_stall", 32'(cpu_stall), 32'(stall));
    if (scr_valid && scr_ready) popped.push_back(scr_addr);
    @(posedge Clock);
    case (r)
      0: begin
        if (wr) begin
          m_ram[idx] = d; m_known[idx] = 1'b1; m_in = d; m_in_known = 1'b1;
        end else begin
          m_in = m_ram[idx]; m_in_known = m_known[idx];
        end
      end
      2: begin m_in = kbd_code; m_in_known = 1'b1; end
      3: begin m_in = {12'b0, m_sw2}; m_in_known = 1'b1; end
      default: begin m_in = '0; m_in_known = 1'b1; end
    endcase
    m_sw2 = m_sw1;
    m_sw1 = SW;
    if (pop) void'(m_q.pop_front());
    if (wr && r == 1 && !stall) m_q.push_back({off, d});
    if (wr && r >= 2 && m_bad < 255) m_bad++;
    #1;
    if (m_in_known) chk("in_m", 32'(in_m), 32'(m_in));
    chk("scr_valid", 32'(scr_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("scr_addr", 32'(scr_addr), 32'(m_q[0][28:16]));
      chk("scr_data", 32'(scr_data), 32'(m_q[0][15:0]));
    end
    chk("bad_wr_cnt", 32'(bad_wr_cnt), 32'(m_bad));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    repeat (2) @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("reset_in_m", 32'(in_m), 32'h0);
    chk("reset_scr_valid", 32'(scr_valid), 32'h0);
    chk("reset_bad", 32'(bad_wr_cnt), 32'h0);

    // RAM round trip and write-first
    data_addr = 15'h0005; write_m = 1'b1; out_m = 16'hBEEF; cycle();
    write_m = 1'b0; cycle();
    chk("ram_read_beef", 32'(in_m), 32'hBEEF);
    write_m = 1'b1; out_m = 16'h1234; cycle();
    chk("ram_write_first", 32'(in_m), 32'h1234);
    write_m = 1'b0; data_addr = 15'h0405; cycle();
    chk("ram_alias", 32'(in_m), 32'h1234);

    // Switches, keyboard, screen read
    SW = 4'b1010; data_addr = 15'h6001;
    cycle(); cycle();
    chk("sw_not_yet", 32'(in_m), 32'h0);
    cycle();
    chk("sw_after_3", 32'(in_m), 32'h000A);
    kbd_code = 16'h0041; data_addr = 15'h6000; cycle();
    chk("kbd_read", 32'(in_m), 32'h0041);
    data_addr = 15'h4000; cycle();
    chk("screen_read", 32'(in_m), 32'h0);

    // Screen backpressure
    scr_ready = 1'b0; write_m = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_addr = 15'(15'h4000 + i); out_m = 16'(16'hA000 + i);
      if (i == 4) chk("stall_5th", 32'(cpu_stall), 32'h1);
      cycle();
    end
    popped.delete();
    scr_ready = 1'b1;
    chk("stall_before_pop", 32'(cpu_stall), 32'h1);
    cycle();
    chk("stall_after_pop", 32'(cpu_stall), 32'h0);
    cycle();
    write_m = 1'b0; data_addr = 15'h7000;
    n = 0;
    while (scr_valid && n < 20) begin cycle(); n++; end
    chk("drain_done", 32'(scr_valid), 32'h0);
    chk("drain_count", 32'(popped.size()), 32'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      chk("drain_order", 32'(popped[i]), 32'(i));

    // Mixed traffic with random ready
    for (int k = 0; k < 80; k++) begin
      scr_ready = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin data_addr = 15'(16 + $urandom_range(0, 7)); write_m = 1'b1; out_m = 16'($urandom); end
        1: begin data_addr = 15'(16 + $urandom_range(0, 7) + 1024 * $urandom_range(0, 3)); write_m = 1'b0; end
        2: begin data_addr = 15'(15'h4000 + $urandom_range(0, 8191)); write_m = 1'b1; out_m = 16'($urandom); end
        default: begin data_addr = 15'(15'h6000 + $urandom_range(0, 2)); write_m = 1'($urandom_range(0, 1)); end
      endcase
      if (k == 40) SW = 4'b0101;
      cycle();
    end
    write_m = 1'b0; scr_ready = 1'b1; data_addr = 15'h0010;
    n = 0;
    while (scr_valid && n < 20) begin cycle(); n++; end
    chk("mixed_drain", 32'(scr_valid), 32'h0);

    // Dropped writes saturate
    write_m = 1'b1; out_m = 16'hDEAD;
    for (int k = 0; k < 300; k++) begin
      data_addr = (k % 2 == 0) ? 15'h6000 : 15'h7000;
      cycle();
    end
    chk("bad_saturated", 32'(bad_wr_cnt), 32'hFF);
    write_m = 1'b0; data_addr = 15'h0005; cycle();
    chk("ram_untouched", 32'(in_m), 32'h1234);
    chk("fifo_untouched", 32'(scr_valid), 32'h0);

    // Reset with entries pending
    scr_ready = 1'b0; write_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_addr = 15'(15'h4100 + i); out_m = 16'(16'h5000 + i); cycle();
    end
    write_m = 1'b0; data_addr = 15'h7000;
    chk("pending_valid", 32'(scr_valid), 32'h1);
    #2 Reset = 1'b1;
    #1;
    chk("reset_async_valid", 32'(scr_valid), 32'h0);
    model_reset();
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("post_reset_in_m", 32'(in_m), 32'h0);
    chk("post_reset_bad", 32'(bad_wr_cnt), 32'h0);
    chk("post_reset_valid", 32'(scr_valid), 32'h0);
    scr_ready = 1'b1;
    repeat (3) cycle();
    data_addr = 15'h0005; cycle();
    chk("ram_kept_over_reset", 32'(in_m), 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
